// File: rtl/obc_link_pkg.sv
// obc_link_pkg: shared types and the agreed answer function for the OBC challenge/response link.
package obc_link_pkg;
  localparam int QW = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, COMPUTE = 2'b01, RESPOND = 2'b10} state_e;
  function automatic logic [QW-1:0] answer_of(input logic [QW-1:0] q);
    return {q[3] ^ q[2], q[2] ^ q[1], q[1] ^ q[0], ~q[0]};
  endfunction
endpackage

// File: rtl/obc_answer_responder_if.sv
// obc_answer_responder_if: question and answer valid/ready channels between checker (master) and responder (slave).
interface obc_answer_responder_if;
  import obc_link_pkg::*;
  logic q_valid, q_ready, corrupt, a_valid, a_ready;
  logic [QW-1:0] question, answer;
  modport master(output q_valid, question, corrupt, a_ready, input q_ready, a_valid, answer);
  modport slave(input q_valid, question, corrupt, a_ready, output q_ready, a_valid, answer);
endinterface

// File: rtl/question_fifo.sv
// question_fifo: synchronous question buffer with wrap-bit pointers and full/empty flags.
module question_fifo
  import obc_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [QW-1:0] din,
  output logic [QW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [QW-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic push_ok, pop_ok;
  always_comb begin
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty = wr_q == rd_q;
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wr_d = wr_q + {{AW{1'b0}}, push_ok};
    rd_d = rd_q + {{AW{1'b0}}, pop_ok};
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/obc_answer_responder.sv
// obc_answer_responder: buffers checker questions, computes each answer after a fixed delay
// and returns it over a valid/ready handshake, with optional bit-0 corruption for fault tests.
module obc_answer_responder
  import obc_link_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int COMPUTE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  obc_answer_responder_if.slave   lnk,
  output logic                    busy,
  output logic [7:0]              answered_count,
  output logic                    drop_flag
);
  localparam int CW = $clog2(COMPUTE_CYCLES) + 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] cur_question_q, cur_question_d, answer_q, answer_d, head;
  logic cur_corrupt_q, cur_corrupt_d, a_valid_q, a_valid_d, drop_q, drop_d, avail_q;
  logic [7:0] count_q, count_d;
  logic pop, full, empty;
  question_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(lnk.q_valid), .pop(pop),
    .din(lnk.question), .dout(head), .full(full), .empty(empty)
  );
  assign lnk.q_ready = !full;
  assign lnk.a_valid = a_valid_q;
  assign lnk.answer = answer_q;
  assign busy = (state_q != IDLE) || !empty;
  assign answered_count = count_q;
  assign drop_flag = drop_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cur_question_d = cur_question_q;
    cur_corrupt_d = cur_corrupt_q;
    answer_d = answer_q;
    a_valid_d = a_valid_q;
    count_d = count_q;
    pop = 1'b0;
    drop_d = drop_q | (lnk.q_valid & full);
    case (state_q)
      IDLE: if (avail_q && !empty) begin
        pop = 1'b1;
        cur_question_d = head;
        cur_corrupt_d = lnk.corrupt;
        cnt_d = CW'(COMPUTE_CYCLES - 1);
        state_d = COMPUTE;
      end
      COMPUTE: if (cnt_q == '0) begin
        answer_d = answer_of(cur_question_q) ^ {{(QW-1){1'b0}}, cur_corrupt_q};
        a_valid_d = 1'b1;
        state_d = RESPOND;
      end else cnt_d = cnt_q - CW'(1);
      RESPOND: if (lnk.a_ready) begin
        a_valid_d = 1'b0;
        count_d = count_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // avail_q sees a newly written head one cycle late, so the pop never sits on the push path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cur_question_q <= '0;
      cur_corrupt_q <= 1'b0;
      answer_q <= '0;
      a_valid_q <= 1'b0;
      count_q <= '0;
      drop_q <= 1'b0;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cur_question_q <= cur_question_d;
      cur_corrupt_q <= cur_corrupt_d;
      answer_q <= answer_d;
      a_valid_q <= a_valid_d;
      count_q <= count_d;
      drop_q <= drop_d;
      avail_q <= !empty;
    end
  end
endmodule

// File: tb/tb_obc_answer_responder.sv
// tb_obc_answer_responder: directed stimulus with a queue-based reference model checked every cycle.
module tb_obc_answer_responder;
  import obc_link_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, drop_flag;
  logic [7:0] answered_count;
  obc_answer_responder_if lnk();
  obc_answer_responder #(.DEPTH(4), .COMPUTE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .lnk(lnk),
    .busy(busy), .answered_count(answered_count), .drop_flag(drop_flag)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0, m_count = 0;
  bit m_drop = 0, prev_hold = 0;
  logic [3:0] prev_ans;
  logic [3:0] exp_q[$];
  logic [3:0] got[$];
  int hs_cyc[$];
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // each answer bit is the question bit XOR its lower neighbour, with bit 0 inverted
  function automatic logic [3:0] ref_answer(input logic [3:0] q);
    return (q ^ {q[2:0], 1'b0}) ^ 4'b0001;
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_count = 0;
      m_drop = 0;
      prev_hold = 0;
      check("rst_a_valid", lnk.a_valid, 0);
      check("rst_answer", lnk.answer, 0);
      check("rst_count", answered_count, 0);
      check("rst_busy", busy, 0);
      check("rst_drop", drop_flag, 0);
      check("rst_q_ready", lnk.q_ready, 1);
    end else begin
      check("count", answered_count, m_count % 256);
      check("drop", drop_flag, m_drop);
      check("busy", busy, exp_q.size() != 0);
      if (prev_hold) begin
        check("hold_valid", lnk.a_valid, 1);
        check("hold_answer", lnk.answer, prev_ans);
      end
      if (lnk.q_valid && lnk.q_ready) exp_q.push_back(ref_answer(lnk.question) ^ {3'b0, lnk.corrupt});
      if (lnk.q_valid && !lnk.q_ready) m_drop = 1;
      if (lnk.a_valid && lnk.a_ready) begin
        if (exp_q.size() == 0) check("spurious_a_valid", lnk.a_valid, 0);
        else check("answer", lnk.answer, exp_q.pop_front());
        got.push_back(lnk.answer);
        hs_cyc.push_back(cyc);
        m_count++;
      end
      prev_hold = lnk.a_valid && !lnk.a_ready;
      prev_ans = lnk.answer;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [3:0] q);
    lnk.q_valid = 1'b1;
    lnk.question = q;
    tick();
    lnk.q_valid = 1'b0;
  endtask
  task automatic wait_valid(input string name);
    int k = 0;
    while (!lnk.a_valid && k < 40) begin
      tick();
      k++;
    end
    check(name, lnk.a_valid, 1);
  endtask
  task automatic wait_answers(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 100) begin
      tick();
      k++;
    end
    check(name, got.size(), n);
    tick();
  endtask
  initial begin
    int t0, c0, g0;
    lnk.q_valid = 1'b0;
    lnk.question = '0;
    lnk.corrupt = 1'b0;
    lnk.a_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    lnk.a_ready = 1'b1;
    t0 = cyc;
    offer(4'b0000);
    wait_valid("t1_valid");
    check("t1_latency", cyc - (t0 + 1), 4);
    wait_answers(1, "t1_done");
    check("t1_answer", got[0], 4'b0001);
    check("t1_count", answered_count, 1);
    offer(4'b1011);
    offer(4'b0110);
    offer(4'b1111);
    wait_answers(4, "t2_done");
    check("t2_ans0", got[1], 4'b1100);
    check("t2_ans1", got[2], 4'b1011);
    check("t2_ans2", got[3], 4'b0000);
    check("t2_gap0", hs_cyc[2] - hs_cyc[1], 4);
    check("t2_gap1", hs_cyc[3] - hs_cyc[2], 4);
    lnk.a_ready = 1'b0;
    offer(4'b0110);
    wait_valid("t3_valid");
    c0 = answered_count;
    repeat (10) tick();
    check("t3_count_stall", answered_count, c0);
    check("t3_valid_stall", lnk.a_valid, 1);
    check("t3_answer_stall", lnk.answer, 4'b1011);
    lnk.a_ready = 1'b1;
    tick();
    check("t3_count_step", answered_count, c0 + 1);
    check("t3_valid_drop", lnk.a_valid, 0);
    lnk.a_ready = 1'b0;
    for (int i = 1; i <= 5; i++) offer(4'(i));
    check("t4_q_ready_full", lnk.q_ready, 0);
    offer(4'b1111);
    check("t4_drop_set", drop_flag, 1);
    lnk.a_ready = 1'b1;
    wait_answers(10, "t4_drain");
    check("t4_drop_sticky", drop_flag, 1);
    check("t4_q_ready_back", lnk.q_ready, 1);
    lnk.corrupt = 1'b1;
    offer(4'b1011);
    wait_answers(11, "t5_done");
    lnk.corrupt = 1'b0;
    check("t5_corrupt", got[10], 4'b1101);
    lnk.a_ready = 1'b0;
    offer(4'b0011);
    offer(4'b0101);
    offer(4'b1001);
    wait_valid("t6_valid");
    g0 = got.size();
    reset = 1'b0;
    #1;
    check("t6_valid_cleared", lnk.a_valid, 0);
    check("t6_count_cleared", answered_count, 0);
    repeat (2) tick();
    reset = 1'b1;
    lnk.a_ready = 1'b1;
    repeat (15) tick();
    check("t6_no_answers", got.size(), g0);
    check("t6_count_zero", answered_count, 0);
    check("t6_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/obc_answer_responder.md
# obc_answer_responder

OBC-side responder for the error-checking challenge/response link. Accepts 4-bit questions from the checker over a valid/ready handshake and buffers them in a small FIFO. For each question it computes the agreed answer after a fixed processing delay and returns it over a second valid/ready handshake. Sits in the OBC model/bench path opposite the checker, and supports deliberate answer corruption so the checker's fail path can be exercised.

## Interface
- `DEPTH`, 4: question FIFO entries; power of two, ≥2.
- `COMPUTE_CYCLES`, 2: cycles spent in COMPUTE per question; ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `q_valid`  in  1  question presented.
- `question`  in  4  question value.
- `q_ready`  out  1  responder can accept; equals !fifo_full.
- `corrupt`  in  1  fault injection; sampled at pop, flips answer bit 0.
- `a_valid`  out  1  answer presented.
- `answer`  out  4  answer value; stable while `a_valid` and not `a_ready`.
- `a_ready`  in  1  checker accepts answer.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.
- `answered_count`  out  8  completed answer handshakes, wraps 255→0.
- `drop_flag`  out  1  sticky; set when `q_valid && !q_ready`.

## Operation
- Answer function, with q = question: a[0] = ~q[0]; a[1] = q[0]^q[1]; a[2] = q[1]^q[2]; a[3] = q[2]^q[3].
- Push on `q_valid && q_ready`. `q_ready` depends only on full; a pop in the same cycle does not free space for a push.
- FSM states: IDLE, COMPUTE, RESPOND.
  - IDLE: if the FIFO is non-empty, pop the head into `cur_q`, latch `corrupt` into `cur_corrupt`, load the delay counter, and go to COMPUTE. Otherwise stay in IDLE.
  - COMPUTE: decrement the counter for `COMPUTE_CYCLES` cycles. On the last cycle, register `answer` = f(`cur_q`) ^ {3'b0, `cur_corrupt`} and go to RESPOND.
  - RESPOND: `a_valid` = 1. On `a_ready`, increment `answered_count`, drop `a_valid`, and go to IDLE. Hold `answer` unchanged until then.
- Questions are answered strictly in arrival order, one at a time.
- `drop_flag` is cleared only by reset. A dropped question is discarded and produces no answer.
- Reset mid-operation: FIFO contents, any in-flight question and any pending answer are discarded. There is no partial handshake after release.

## Timing
- Reset values: `a_valid`=0, `answer`=0, `busy`=0, `answered_count`=0, `drop_flag`=0. FIFO is empty, so `q_ready`=1.
- Minimum latency, with the responder idle and the FIFO empty: `a_valid` rises COMPUTE_CYCLES+2 edges after the accepting edge. That is 4 edges at the default.
- Per-answer throughput: COMPUTE_CYCLES+2 cycles, plus any `a_ready` stall.
- `a_ready` held high: the answer handshake completes on the first RESPOND cycle.
- `a_ready` asserted while `a_valid`=0 is ignored.
- `q_ready` and `busy` are combinational from registered state. `a_valid` and `answer` are registered.

## Structure
- Shared package `obc_link_pkg` holds:
  - the state enum: IDLE=2'b00, COMPUTE=2'b01, RESPOND=2'b10;
  - the 4-bit question/answer width constant;
  - the answer function, so the checker's local-answer logic reuses the same definition.
- One sub-module, `question_fifo`: synchronous FIFO with parameter `DEPTH`, width 4, full/empty flags, pointers one bit wider than the address. It takes the same active-low asynchronous `reset`.
- Everything else lives in `obc_answer_responder`.

## Test plan
- Reset release, then question 4'b0000 with `a_ready`=1 → `answer`=4'b0001, `a_valid` exactly 4 edges after accept, `answered_count`=1.
- Burst of 1011, 0110, 1111 on back-to-back cycles with `a_ready`=1 → answers 1100, 1011, 0000, in order, spaced 4 cycles apart.
- Question 0110 with `a_ready` held low for 10 cycles → `a_valid` and `answer`=1011 stay stable throughout. A single count increment occurs on the cycle `a_ready` rises.
- `a_ready`=0 with 5 questions offered (DEPTH=4, one in flight) → `q_ready` falls once the FIFO holds 4. A further `q_valid` sets `drop_flag`, which stays set after all answers drain.
- Question 1011 with `corrupt`=1 at pop → `answer`=4'b1101.
- Reset pulled low while in RESPOND with 2 entries queued → `a_valid`=0 immediately. After release, no answers appear and `answered_count`=0.
